// File: rtl/oc8051_iram_bist_ctrl.sv
// March C- built-in self-test initiator for the 8051 internal RAM buffer.
// Drives the RAM read/write port pair, checks registered read data and captures the first failure.
module oc8051_iram_bist_ctrl #(
  parameter int         ADDR_W = 4,
  parameter logic [7:0] BG     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] ram_rd_addr,
  output logic       ram_rd_en,
  input  logic [7:0] ram_rd_data,
  output logic [7:0] ram_wr_addr,
  output logic [7:0] ram_wr_data,
  output logic       ram_wr,
  output logic       ram_wr_en,
  output logic       bist_busy,
  output logic       bist_done,
  output logic       bist_fail,
  output logic [2:0] fail_elem,
  output logic [7:0] fail_addr,
  output logic [7:0] fail_exp,
  output logic [7:0] fail_got
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [2:0]        f_elem_q, f_elem_d;
  logic [7:0]        f_addr_q, f_addr_d;
  logic [7:0]        f_exp_q, f_exp_d;
  logic [7:0]        f_got_q, f_got_d;

  logic              running;
  logic              rd_cyc;
  logic              cmp_cyc;
  logic              mismatch;
  logic              last_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [2:0]        elem_nxt;
  logic [7:0]        exp_data;

  function automatic logic elem_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [7:0] elem_exp(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? ~BG : BG;
  endfunction

  // Element 0 writes "0"; elements 1 and 3 write "1"; elements 2 and 4 write "0".
  function automatic logic [7:0] elem_wdata(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? ~BG : BG;
  endfunction

  always_comb begin
    running   = (state_q == S_RUN);
    rd_cyc    = running && (elem_q != 3'd0) && !phase_q;
    cmp_cyc   = running && (elem_q != 3'd0) && phase_q;
    exp_data  = elem_exp(elem_q);
    mismatch  = cmp_cyc && (ram_rd_data != exp_data);
    last_addr = elem_desc(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
    step_addr = elem_desc(elem_q) ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    elem_nxt  = elem_q + 3'd1;
  end

  // RAM port decode: reads only in R cycles, writes in element 0 and in passing C cycles.
  always_comb begin
    ram_rd_en   = rd_cyc;
    ram_rd_addr = rd_cyc ? 8'(addr_q) : 8'h00;
    ram_wr      = running &&
                  ((elem_q == 3'd0) || (cmp_cyc && (elem_q != ELEM_LAST) && !mismatch));
    ram_wr_en   = ram_wr;
    ram_wr_addr = ram_wr ? 8'(addr_q) : 8'h00;
    ram_wr_data = ram_wr ? elem_wdata(elem_q) : 8'h00;
  end

  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    done_d   = done_q;
    fail_d   = fail_q;
    f_elem_d = f_elem_q;
    f_addr_d = f_addr_q;
    f_exp_d  = f_exp_q;
    f_got_d  = f_got_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          elem_d   = 3'd0;
          addr_d   = '0;
          phase_d  = 1'b0;
          done_d   = 1'b0;
          fail_d   = 1'b0;
          f_elem_d = 3'd0;
          f_addr_d = 8'h00;
          f_exp_d  = 8'h00;
          f_got_d  = 8'h00;
        end
      end
      S_RUN: begin
        if (elem_q == 3'd0) begin
          if (last_addr) begin
            elem_d = 3'd1;
            addr_d = '0;
          end else begin
            addr_d = step_addr;
          end
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else if (mismatch) begin
          state_d  = S_DONE;
          phase_d  = 1'b0;
          done_d   = 1'b1;
          fail_d   = 1'b1;
          f_elem_d = elem_q;
          f_addr_d = 8'(addr_q);
          f_exp_d  = exp_data;
          f_got_d  = ram_rd_data;
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = step_addr;
          end else if (elem_q == ELEM_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            elem_d = elem_nxt;
            addr_d = elem_desc(elem_nxt) ? ADDR_LAST : '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      elem_q   <= 3'd0;
      addr_q   <= '0;
      phase_q  <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      f_elem_q <= 3'd0;
      f_addr_q <= 8'h00;
      f_exp_q  <= 8'h00;
      f_got_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      f_elem_q <= f_elem_d;
      f_addr_q <= f_addr_d;
      f_exp_q  <= f_exp_d;
      f_got_q  <= f_got_d;
    end
  end

  assign bist_busy = (state_q == S_RUN);
  assign bist_done = done_q;
  assign bist_fail = fail_q;
  assign fail_elem = f_elem_q;
  assign fail_addr = f_addr_q;
  assign fail_exp  = f_exp_q;
  assign fail_got  = f_got_q;

endmodule
